// File: rtl/layer_4_maxpool_2x2.sv
// Streaming 2x2 / stride-2 max-pool for fp32 raster pixel streams.
// Even rows fold horizontal pairs into a half-width line buffer; odd rows finish each window.
module layer_4_maxpool_2x2 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMG_SIZE   = 104
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int unsigned HALF  = IMG_SIZE / 2;
    localparam int unsigned CNT_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam int unsigned IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IMG_SIZE - 1);

    logic [CNT_W-1:0]      r_col;
    logic [CNT_W-1:0]      r_row;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_frame_done;
    logic [DATA_WIDTH-1:0] r_linebuf [HALF];

    logic                  w_row_odd;
    logic                  w_col_odd;
    logic                  w_col_last;
    logic                  w_row_last;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_lb_rd;
    logic [DATA_WIDTH-1:0] w_cmp_a;
    logic [DATA_WIDTH-1:0] w_max;

    // Monotonic unsigned key: negatives are bit-inverted, positives get the sign bit set,
    // so -0 sorts just below +0 and plain unsigned compare orders the floats.
    function automatic logic [DATA_WIDTH-1:0] f_key(input logic [DATA_WIDTH-1:0] x);
        f_key = x[DATA_WIDTH-1] ? ~x : (x | {1'b1, {(DATA_WIDTH-1){1'b0}}});
    endfunction

    assign w_row_odd  = r_row[0];
    assign w_col_odd  = r_col[0];
    assign w_col_last = (r_col == LAST);
    assign w_row_last = (r_row == LAST);
    assign w_idx      = IDX_W'(r_col >> 1);
    assign w_lb_rd    = r_linebuf[w_idx];

    // One shared comparator: the new pixel against either the line buffer or the held pair.
    assign w_cmp_a = (w_row_odd && !w_col_odd) ? w_lb_rd : r_hold;
    assign w_max   = (f_key(data_in) > f_key(w_cmp_a)) ? data_in : w_cmp_a;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_hold       <= '0;
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            if (valid_in) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + CNT_W'(1);
                end else begin
                    r_col <= r_col + CNT_W'(1);
                end

                case ({w_row_odd, w_col_odd})
                    2'b00: r_hold <= data_in;
                    2'b10: r_hold <= w_max;
                    2'b11: begin
                        r_data_out   <= w_max;
                        r_valid_out  <= 1'b1;
                        r_frame_done <= w_row_last && w_col_last;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Line buffer holds no reset: every slot is written on an even row before the odd row reads it.
    always_ff @(posedge Clk) begin
        if (valid_in && !w_row_odd && w_col_odd) begin
            r_linebuf[w_idx] <= w_max;
        end
    end

    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_layer_4_maxpool_2x2.sv
// Bench for layer_4_maxpool_2x2: a 4x4 and a 104x104 instance checked every cycle against
// window maxima computed directly from the stored frame using real-valued comparison.
module tb_layer_4_maxpool_2x2;

    localparam int unsigned NA = 4;
    localparam int unsigned NB = 104;

    logic        clk;
    logic        rst;
    logic [31:0] din_a, din_b;
    logic        vin_a, vin_b;
    logic [31:0] dout_a, dout_b;
    logic        vout_a, vout_b;
    logic        fd_a, fd_b;

    logic [31:0] exp_dout_a, exp_dout_b;
    logic        exp_v_a, exp_v_b, exp_fd_a, exp_fd_b;

    logic [31:0] frm [NB*NB];
    logic [31:0] obs_a [$];
    int          nv_b, nfd_b;
    int          n_checks, n_errors;

    layer_4_maxpool_2x2 #(.DATA_WIDTH(32), .IMG_SIZE(NA)) u_dut_a (
        .Clk(clk), .Rst(rst), .data_in(din_a), .valid_in(vin_a),
        .data_out(dout_a), .valid_out(vout_a), .frame_done(fd_a)
    );

    layer_4_maxpool_2x2 #(.DATA_WIDTH(32), .IMG_SIZE(NB)) u_dut_b (
        .Clk(clk), .Rst(rst), .data_in(din_b), .valid_in(vin_b),
        .data_out(dout_b), .valid_out(vout_b), .frame_done(fd_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // fp32 (normals and zeros only) to real; zero sign is handled by the caller
    function automatic real to_real(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] fp_of_int(input int k);
        logic [63:0] d;
        d = $realtobits(real'(k));
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
        real ra, rb;
        ra = to_real(a);
        rb = to_real(b);
        if (rb > ra) return b;
        if (rb == ra && a[31] && !b[31]) return b;
        return a;
    endfunction

    function automatic logic [31:0] rand_px();
        if ($urandom_range(7) == 0) return {1'($urandom_range(1)), 31'd0};
        return {1'($urandom_range(1)), 8'($urandom_range(134, 120)), 23'($urandom)};
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        vin_a = 1'b0; exp_v_a = 1'b0; exp_fd_a = 1'b0;
        vin_b = 1'b0; exp_v_b = 1'b0; exp_fd_b = 1'b0;
    endtask

    // Drive a frame from frm; max_beats > 0 stops early
    task automatic run_frame(input bit sel, input int n, input int gap_pct, input int max_beats);
        int beats;
        logic [31:0] w;
        bit ev, efd;
        beats = 0;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                if (gap_pct > 0)
                    while ($urandom_range(99) < gap_pct) idle_cycle();
                ev = (r % 2 == 1) && (c % 2 == 1);
                efd = ev && (r == n - 1) && (c == n - 1);
                w = '0;
                if (ev)
                    w = ref_max(ref_max(frm[(r-1)*n + c-1], frm[(r-1)*n + c]),
                                ref_max(frm[r*n + c-1], frm[r*n + c]));
                @(negedge clk);
                if (!sel) begin
                    din_a = frm[r*n + c]; vin_a = 1'b1; exp_v_a = ev; exp_fd_a = efd;
                    if (ev) exp_dout_a = w;
                    vin_b = 1'b0; exp_v_b = 1'b0; exp_fd_b = 1'b0;
                end else begin
                    din_b = frm[r*n + c]; vin_b = 1'b1; exp_v_b = ev; exp_fd_b = efd;
                    if (ev) exp_dout_b = w;
                    vin_a = 1'b0; exp_v_a = 1'b0; exp_fd_a = 1'b0;
                end
                beats++;
                if (max_beats > 0 && beats == max_beats) return;
            end
        end
    endtask

    task automatic check_obs4(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] ev [4];
        ev = '{e0, e1, e2, e3};
        check_val({tag, "_count"}, 32'(obs_a.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs_a.size(); i++)
            check_val({tag, "_px"}, obs_a[i], ev[i]);
    endtask

    always begin
        @(posedge clk);
        #1;
        check_val("a_valid", 32'(vout_a), 32'(exp_v_a));
        check_val("a_fdone", 32'(fd_a), 32'(exp_fd_a));
        check_val("a_data", dout_a, exp_dout_a);
        check_val("b_valid", 32'(vout_b), 32'(exp_v_b));
        check_val("b_fdone", 32'(fd_b), 32'(exp_fd_b));
        check_val("b_data", dout_b, exp_dout_b);
        if (vout_a) obs_a.push_back(dout_a);
        if (vout_b) nv_b++;
        if (fd_b) nfd_b++;
    end

    initial begin
        n_checks = 0; n_errors = 0; nv_b = 0; nfd_b = 0;
        rst = 1'b1;
        din_a = '0; din_b = '0; vin_a = 1'b0; vin_b = 1'b0;
        exp_dout_a = '0; exp_dout_b = '0;
        exp_v_a = 1'b0; exp_v_b = 1'b0; exp_fd_a = 1'b0; exp_fd_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_cycle();

        // 1: ascending 1..16, continuous
        for (int i = 0; i < 16; i++) frm[i] = fp_of_int(i + 1);
        obs_a.delete();
        run_frame(1'b0, NA, 0, 0);
        idle_cycle(); idle_cycle();
        check_obs4("s1", 32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000);

        // 2: all negative
        for (int i = 0; i < 16; i++) frm[i] = fp_of_int(-(i + 1));
        obs_a.delete();
        run_frame(1'b0, NA, 0, 0);
        idle_cycle(); idle_cycle();
        check_obs4("s2", 32'hBF800000, 32'hC0400000, 32'hC1100000, 32'hC1300000);

        // 3: signed zeros and a mixed-sign window
        for (int i = 0; i < 16; i++) frm[i] = rand_px();
        frm[0] = 32'h80000000; frm[1] = 32'h00000000; frm[4] = 32'h80000000; frm[5] = 32'h80000000;
        frm[2] = 32'hBF000000; frm[3] = 32'h3E800000; frm[6] = 32'hC0000000; frm[7] = 32'h00000000;
        frm[8] = 32'h80000000; frm[9] = 32'h80000000; frm[12] = 32'h80000000; frm[13] = 32'h80000000;
        obs_a.delete();
        run_frame(1'b0, NA, 0, 0);
        idle_cycle(); idle_cycle();
        check_val("s3_count", 32'(obs_a.size()), 32'd4);
        if (obs_a.size() >= 3) begin
            check_val("s3_zero", obs_a[0], 32'h00000000);
            check_val("s3_mixed", obs_a[1], 32'h3E800000);
            check_val("s3_negzero", obs_a[2], 32'h80000000);
        end

        // 4: scenario 1 data with ~50% gaps
        for (int i = 0; i < 16; i++) frm[i] = fp_of_int(i + 1);
        obs_a.delete();
        run_frame(1'b0, NA, 50, 0);
        repeat (3) idle_cycle();
        check_obs4("s4", 32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000);

        // 5: reset after 9 beats, then a clean frame
        run_frame(1'b0, NA, 0, 9);
        @(negedge clk);
        rst = 1'b1;
        vin_a = 1'b0; vin_b = 1'b0;
        exp_v_a = 1'b0; exp_fd_a = 1'b0; exp_v_b = 1'b0; exp_fd_b = 1'b0;
        exp_dout_a = '0; exp_dout_b = '0;
        #1;
        check_val("s5_async_data", dout_a, 32'h0);
        check_val("s5_async_valid", 32'(vout_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        obs_a.delete();
        run_frame(1'b0, NA, 0, 0);
        idle_cycle(); idle_cycle();
        check_obs4("s5", 32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000);

        // 6: two back-to-back random 104x104 frames
        nv_b = 0; nfd_b = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NB*NB; i++)
                frm[i] = ($urandom_range(9) == 0 && i > 0) ? frm[i-1] : rand_px();
            run_frame(1'b1, NB, 0, 0);
        end
        idle_cycle(); idle_cycle();
        check_val("s6_outputs", 32'(nv_b), 32'd5408);
        check_val("s6_frame_done", 32'(nfd_b), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/layer_4_maxpool_2x2.md
Name: layer_4_maxpool_2x2

Overview:
- Streaming 2x2, stride-2 max-pooling stage for YOLOv3Tiny layer 4.
- Sits directly downstream of a layer-4 feature-map block. Consumes that block's raster-ordered IEEE-754 single-precision pixel stream, one pixel per valid beat.
- Emits the pooled map (IMG_SIZE/2 x IMG_SIZE/2) in raster order to the layer-5 input.
- One instance is used per output feature map.

Parameters:
- DATA_WIDTH, 32, pixel width; fp32 bit pattern.
- IMG_SIZE, 104, input width and height in pixels; must be even and >= 2.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  input pixel; sampled only when valid_in=1.
- valid_in  input  1  input beat qualifier; gaps allowed; no backpressure.
- data_out  output  DATA_WIDTH  pooled pixel.
- valid_out  output  1  one-cycle pulse per pooled pixel.
- frame_done  output  1  one-cycle pulse coincident with the last pooled pixel of a frame.

Behaviour:
- Reset: col=0, row=0, hold_reg=0, data_out=0, valid_out=0, frame_done=0. Line buffer contents are don't-care; every entry is written before it is read.
- Counters:
  - col counts 0..IMG_SIZE-1 and advances only on a valid_in beat.
  - At col=IMG_SIZE-1, col wraps to 0 and row increments.
  - At row=IMG_SIZE-1 with col=IMG_SIZE-1, both wrap to 0.
  - With valid_in=0, all state is frozen.
- Compare function max(a,b):
  - Ordering key is k(x) = x[31] ? ~x : x | 32'h80000000, compared unsigned.
  - Result is the operand with the larger key; on a tie, result is a.
  - -0 orders below +0. NaN inputs are not supported (upstream never produces them).
- Line buffer: IMG_SIZE/2 entries x DATA_WIDTH, combinational read, synchronous write, indexed by col>>1.
- Per valid beat, by (row parity, col parity):
  - even row, even col: hold_reg <= data_in.
  - even row, odd col: linebuf[col>>1] <= max(hold_reg, data_in).
  - odd row, even col: hold_reg <= max(linebuf[col>>1], data_in).
  - odd row, odd col: data_out <= max(hold_reg, data_in); valid_out <= 1 for one cycle; frame_done <= 1 if row=IMG_SIZE-1 and col=IMG_SIZE-1.
- Output registers:
  - valid_out and frame_done are 0 in every other cycle.
  - data_out holds its last value between pulses.
- Latency: valid_out asserts exactly 1 cycle after the beat carrying the bottom-right pixel of each 2x2 window.
- Throughput:
  - Back-to-back input gives one output every 2 beats on odd rows and none on even rows.
  - Total of (IMG_SIZE/2)^2 outputs per frame.
- Frame boundary: the next frame may start on the beat immediately after the last pixel. No idle cycle is required, and there is no cross-frame state leakage.
- Reset mid-frame: all counters and outputs return to reset values immediately (asynchronously). The next accepted beat is treated as pixel (0,0) of a new frame.
- Mapping of the (r,c) pixel pair is fixed: output (i,j) = max over input rows 2i..2i+1 and columns 2j..2j+1.

Test Plan:
1. IMG_SIZE=4, continuous valid_in, pixels = fp32 of 1.0..16.0 in raster order -> outputs 6.0, 8.0, 14.0, 16.0 (32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000), each 1 cycle after input beats 6, 8, 14, 16; frame_done only with 16.0.
2. IMG_SIZE=4, all pixels negative (-1.0..-16.0) -> outputs -1.0, -3.0, -9.0, -11.0 (32'hBF800000, 32'hC0400000, 32'hC1100000, 32'hC1300000).
3. Window containing +0 and -0 only -> data_out = 32'h00000000. Window {-0.5, 0.25, -2.0, 0.0} -> 32'h3E800000.
4. IMG_SIZE=4, valid_in randomly low ~50% of cycles -> same output values as scenario 1; valid_out count = 4; outputs unchanged during gaps.
5. Assert Rst after 9 input beats, release, then stream scenario 1 data -> no valid_out during or after the reset beat from the stale data; outputs 6, 8, 14, 16 from the new frame.
6. IMG_SIZE=104, two back-to-back random frames -> 2704 outputs per frame matching the reference model; exactly 2 frame_done pulses.
